nn_forward_seq: RTL and testbench

- Forward-propagation engine for the 2-3-2 fixed-point network. Sits directly downstream of the weight/bias ROM and consumes its 17 registered words.
- One shared signed multiply-accumulate unit computes 3 hidden neurons, then 2 output neurons, on a start/done handshake.
- Results feed the output/compare stage.

---
 rtl/nn_forward_seq.sv | 274 +++++++++++++++++++++++++++
 tb/tb_nn_forward_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/nn_forward_seq.sv
// nn_forward_seq: forward pass of the 2-3-2 fixed-point network.
// One shared signed MAC evaluates hidden neurons 1..3 (2 terms each, state L1).
// It then evaluates output neurons 1..2 (3 terms each, state L2).
// A run takes 12 cycles after the start edge and finishes with a one-cycle done pulse.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              inference request, sampled only while idle
//   x1, x2             network inputs, captured when start is accepted
//   wa1*, wb1*         layer-1 weights (input a/b to hidden 1..3), sampled live
//   wa2*, wb2*, wc2*   layer-2 weights (hidden a/b/c to output 1..2), sampled live
//   bias1*, bias2*     hidden / output biases, sampled live
//   busy               inference in progress
//   done               one-cycle pulse when y1/y2 update
//   y1, y2             network outputs, held between runs
//
// Optional build macro NN_OUT_ACT_EN: when defined, the output layer also
// applies the hard-sigmoid activation. Otherwise y1/y2 are the linear sums.
module nn_forward_seq #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned frac   = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DWIDTH-1:0] x1,
    input  logic [DWIDTH-1:0] x2,
    input  logic [DWIDTH-1:0] wa11,
    input  logic [DWIDTH-1:0] wa12,
    input  logic [DWIDTH-1:0] wa13,
    input  logic [DWIDTH-1:0] wb11,
    input  logic [DWIDTH-1:0] wb12,
    input  logic [DWIDTH-1:0] wb13,
    input  logic [DWIDTH-1:0] wa21,
    input  logic [DWIDTH-1:0] wa22,
    input  logic [DWIDTH-1:0] wb21,
    input  logic [DWIDTH-1:0] wb22,
    input  logic [DWIDTH-1:0] wc21,
    input  logic [DWIDTH-1:0] wc22,
    input  logic [DWIDTH-1:0] bias11,
    input  logic [DWIDTH-1:0] bias12,
    input  logic [DWIDTH-1:0] bias13,
    input  logic [DWIDTH-1:0] bias21,
    input  logic [DWIDTH-1:0] bias22,
    output logic              busy,
    output logic              done,
    output logic [DWIDTH-1:0] y1,
    output logic [DWIDTH-1:0] y2
);

    localparam int unsigned PW = 2 * DWIDTH;
    localparam int unsigned XW = DWIDTH + 1;

    // 1.0 and 0.5 at one extra bit so the activation cannot wrap before clamping
    localparam logic signed [XW-1:0] ONE_X  = {{(DWIDTH - frac){1'b0}}, 1'b1, {frac{1'b0}}};
    localparam logic signed [XW-1:0] HALF_X = ONE_X >>> 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        L1   = 2'd1,
        L2   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        j_q, j_d;
    logic [1:0]        k_q, k_d;
    logic [DWIDTH-1:0] acc_q, acc_d;
    logic [DWIDTH-1:0] x1_q, x1_d;
    logic [DWIDTH-1:0] x2_q, x2_d;
    logic [DWIDTH-1:0] h1_q, h1_d;
    logic [DWIDTH-1:0] h2_q, h2_d;
    logic [DWIDTH-1:0] h3_q, h3_d;
    logic [DWIDTH-1:0] y1_hold_q, y1_hold_d;
    logic [DWIDTH-1:0] y1_q, y1_d;
    logic [DWIDTH-1:0] y2_q, y2_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic signed [DWIDTH-1:0] op_a_c;
    logic signed [DWIDTH-1:0] op_w_c;
    logic [DWIDTH-1:0]        op_b_c;
    logic signed [PW-1:0]     prod_full_c;
    logic [DWIDTH-1:0]        prod_c;
    logic [DWIDTH-1:0]        sum_c;
    logic [DWIDTH-1:0]        act_c;
    logic [DWIDTH-1:0]        out_c;

    // Hard sigmoid: (v >>> 2) + 0.5, clamped to [0, 1.0]
    function automatic logic [DWIDTH-1:0] act_fn(input logic [DWIDTH-1:0] v);
        logic signed [XW-1:0] t;
        t = $signed({v[DWIDTH-1], v}) >>> 2;
        t = t + HALF_X;
        if (t < 0) begin
            return '0;
        end else if (t > ONE_X) begin
            return DWIDTH'(ONE_X);
        end else begin
            return DWIDTH'(t);
        end
    endfunction

    // Operand selection for the current (neuron j, term k)
    always_comb begin
        op_a_c = '0;
        op_w_c = '0;
        op_b_c = '0;
        case (state_q)
            L1: begin
                op_a_c = (k_q == 2'd0) ? x1_q : x2_q;
                case (j_q)
                    2'd0: begin
                        op_w_c = (k_q == 2'd0) ? wa11 : wb11;
                        op_b_c = bias11;
                    end
                    2'd1: begin
                        op_w_c = (k_q == 2'd0) ? wa12 : wb12;
                        op_b_c = bias12;
                    end
                    2'd2: begin
                        op_w_c = (k_q == 2'd0) ? wa13 : wb13;
                        op_b_c = bias13;
                    end
                    default: ;
                endcase
            end
            L2: begin
                case (k_q)
                    2'd0: begin
                        op_a_c = h1_q;
                        op_w_c = (j_q == 2'd0) ? wa21 : wa22;
                    end
                    2'd1: begin
                        op_a_c = h2_q;
                        op_w_c = (j_q == 2'd0) ? wb21 : wb22;
                    end
                    2'd2: begin
                        op_a_c = h3_q;
                        op_w_c = (j_q == 2'd0) ? wc21 : wc22;
                    end
                    default: ;
                endcase
                op_b_c = (j_q == 2'd0) ? bias21 : bias22;
            end
            default: ;
        endcase
    end

    // Shared MAC: full product, floor-shift by frac, wrap-around accumulate
    assign prod_full_c = PW'(op_a_c) * PW'(op_w_c);
    assign prod_c      = DWIDTH'(prod_full_c >>> frac);
    assign sum_c       = ((k_q == 2'd0) ? op_b_c : acc_q) + prod_c;
    assign act_c       = act_fn(sum_c);

`ifdef NN_OUT_ACT_EN
    assign out_c = act_c;
`else
    assign out_c = sum_c;
`endif

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        j_d       = j_q;
        k_d       = k_q;
        acc_d     = acc_q;
        x1_d      = x1_q;
        x2_d      = x2_q;
        h1_d      = h1_q;
        h2_d      = h2_q;
        h3_d      = h3_q;
        y1_hold_d = y1_hold_q;
        y1_d      = y1_q;
        y2_d      = y2_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x1_d    = x1;
                    x2_d    = x2;
                    j_d     = 2'd0;
                    k_d     = 2'd0;
                    busy_d  = 1'b1;
                    state_d = L1;
                end
            end
            L1: begin
                acc_d = sum_c;
                if (k_q == 2'd1) begin
                    case (j_q)
                        2'd0:    h1_d = act_c;
                        2'd1:    h2_d = act_c;
                        default: h3_d = act_c;
                    endcase
                    k_d = 2'd0;
                    if (j_q == 2'd2) begin
                        j_d     = 2'd0;
                        state_d = L2;
                    end else begin
                        j_d = j_q + 2'd1;
                    end
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            L2: begin
                acc_d = sum_c;
                if (k_q == 2'd2) begin
                    k_d = 2'd0;
                    if (j_q == 2'd0) begin
                        // y1 is held back so both outputs appear together
                        y1_hold_d = out_c;
                        j_d       = 2'd1;
                    end else begin
                        y1_d    = y1_hold_q;
                        y2_d    = out_c;
                        j_d     = 2'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            j_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            h1_q      <= '0;
            h2_q      <= '0;
            h3_q      <= '0;
            y1_hold_q <= '0;
            y1_q      <= '0;
            y2_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            h1_q      <= h1_d;
            h2_q      <= h2_d;
            h3_q      <= h3_d;
            y1_hold_q <= y1_hold_d;
            y1_q      <= y1_d;
            y2_q      <= y2_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign y1   = y1_q;
    assign y2   = y2_q;

endmodule

// File: tb/tb_nn_forward_seq.sv
// Directed testbench for nn_forward_seq with hand-computed expected values.
// Honours NN_OUT_ACT_EN so the same bench covers both output-layer builds.
module tb_nn_forward_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] x1, x2;
    logic [31:0] wa11, wa12, wa13, wb11, wb12, wb13;
    logic [31:0] wa21, wa22, wb21, wb22, wc21, wc22;
    logic [31:0] bias11, bias12, bias13, bias21, bias22;
    logic        busy, done;
    logic [31:0] y1, y2;

    int total;
    int bad;

    nn_forward_seq #(.DWIDTH(32), .frac(24)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x1(x1), .x2(x2),
        .wa11(wa11), .wa12(wa12), .wa13(wa13),
        .wb11(wb11), .wb12(wb12), .wb13(wb13),
        .wa21(wa21), .wa22(wa22), .wb21(wb21), .wb22(wb22),
        .wc21(wc21), .wc22(wc22),
        .bias11(bias11), .bias12(bias12), .bias13(bias13),
        .bias21(bias21), .bias22(bias22),
        .busy(busy), .done(done), .y1(y1), .y2(y2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for each directed vector, per output-layer build
`ifdef NN_OUT_ACT_EN
    localparam logic [31:0] E_BASE   = 32'h00E0_0000;
    localparam logic [31:0] E_UP_Y1  = 32'h00C0_0000;
    localparam logic [31:0] E_ZERO   = 32'h0080_0000;
    localparam logic [31:0] E_TRUNC  = 32'h009F_FFFF;
`else
    localparam logic [31:0] E_BASE   = 32'h0180_0000;
    localparam logic [31:0] E_UP_Y1  = 32'h0100_0000;
    localparam logic [31:0] E_ZERO   = 32'h0000_0000;
    localparam logic [31:0] E_TRUNC  = 32'h007F_FFFF;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_vec();
        x1 = '0; x2 = '0;
        wa11 = '0; wa12 = '0; wa13 = '0; wb11 = '0; wb12 = '0; wb13 = '0;
        wa21 = '0; wa22 = '0; wb21 = '0; wb22 = '0; wc21 = '0; wc22 = '0;
        bias11 = '0; bias12 = '0; bias13 = '0; bias21 = '0; bias22 = '0;
    endtask

    // Vector 1: layer-2 weights all 1.0, inputs 1.0, layer-1 all zero
    task automatic base_vec();
        clear_vec();
        x1 = 32'h0100_0000; x2 = 32'h0100_0000;
        wa21 = 32'h0100_0000; wa22 = 32'h0100_0000;
        wb21 = 32'h0100_0000; wb22 = 32'h0100_0000;
        wc21 = 32'h0100_0000; wc22 = 32'h0100_0000;
    endtask

    // Pulse start for one cycle, then wait for done and check latency/results
    task automatic run_one(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                           input bit wiggle);
        int lat;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (wiggle) begin
            x1 = 32'h7FFF_FFFF;
            x2 = 32'h8000_0000;
        end
        check({tag, "_busy_run"}, 32'(busy), 32'd1);
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 30 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat = i;
            if (done) seen = 1'b1;
        end
        if (!seen) lat = -1;
        check({tag, "_latency"}, 32'(lat), 32'd12);
        check({tag, "_y1"}, y1, e1);
        check({tag, "_y2"}, y2, e2);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    int done_cnt;
    int first_done;
    int second_done;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        clear_vec();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_y1", y1, 32'd0);
        check("rst_y2", y2, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        base_vec();
        run_one("base", E_BASE, E_BASE, 1'b0);

        // Upper clamp: h1 = act(2.0) = 1.0, y1 = h1 * 1.0
        clear_vec();
        wa11 = 32'h0100_0000; x1 = 32'h0200_0000; wa21 = 32'h0100_0000;
        run_one("upclamp", E_UP_Y1, E_ZERO, 1'b0);

        // Lower clamp: h1 = act(-4.0) = 0
        clear_vec();
        x1 = 32'hFC00_0000; wa11 = 32'h0100_0000; wa21 = 32'h0100_0000;
        run_one("loclamp", E_ZERO, E_ZERO, 1'b0);

        // Truncation: -1 lsb * 0.5 floors to -1 lsb, act gives 0x007FFFFF
        clear_vec();
        x1 = 32'hFFFF_FFFF; wa11 = 32'h0080_0000; wa21 = 32'h0100_0000;
        run_one("trunc", E_TRUNC, E_ZERO, 1'b0);

        // Inputs change after capture: results follow the captured values
        base_vec();
        run_one("xcapt", E_BASE, E_BASE, 1'b1);

        // start at cycles 0, 3, 11 and in the done cycle (13)
        base_vec();
        done_cnt    = 0;
        first_done  = -1;
        second_done = -1;
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            start = (c == 0 || c == 3 || c == 11 || c == 13);
            @(posedge clk);
            #1;
            if (done) begin
                done_cnt++;
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
        end
        start = 1'b0;
        check("b2b_first_done", 32'(first_done), 32'd12);
        check("b2b_second_done", 32'(second_done), 32'd25);
        check("b2b_done_count", 32'(done_cnt), 32'd2);
        check("b2b_y1", y1, E_BASE);

        // Reset at cycle 5 of a run aborts it without a done
        base_vec();
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_y1", y1, 32'd0);
        check("abort_y2", y2, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_idle_busy", 32'(busy), 32'd0);
        run_one("after_abort", E_BASE, E_BASE, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
